voice_allocator: RTL and testbench

- Upstream stage of the audio codec block.
- Turns a stream of note press/release events (from keypad/game logic) into four polyphonic voice channels: per-voice key_on level and 16-bit phase increment, which feed the codec's keyN_on/soundN inputs.
- Free voices are allocated lowest-index first; when all four are busy, the least-recently-allocated voice is stolen with an enforced silence gap.

---
 rtl/voice_allocator.sv | 199 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Four-voice note allocator: turns press/release events into per-voice gate and
// phase-increment outputs, lowest free voice first, stealing the oldest voice with a silence gap.
module voice_allocator #(
    parameter int NOTE_COUNT = 36,
    parameter int STEAL_GAP  = 768
) (
    input  logic        iCLK_18_4,
    input  logic        iRST,
    input  logic        iNote_valid,
    input  logic [5:0]  iNote_code,
    input  logic        iNote_on,
    output logic        oNote_ready,
    input  logic        iAll_off,
    output logic        oKey1_on,
    output logic        oKey2_on,
    output logic        oKey3_on,
    output logic        oKey4_on,
    output logic [15:0] oSound1,
    output logic [15:0] oSound2,
    output logic [15:0] oSound3,
    output logic [15:0] oSound4,
    output logic        oErr
);

    localparam int GAP_W = $clog2(STEAL_GAP);

    typedef enum logic [1:0] {IDLE, MATCH, GAP, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [5:0]        code_q, code_d;
    logic              on_q, on_d;
    logic [3:0]        key_q, key_d;
    logic [3:0]        active_q, active_d;
    logic [3:0][15:0]  sound_q, sound_d;
    logic [3:0][5:0]   held_q, held_d;
    logic [3:0][1:0]   rank_q, rank_d;
    logic [1:0]        target_q, target_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic              hit, free;
    logic [1:0]        hit_idx, free_idx, old_idx;

    // Phase increment = round(f_note * 1.28), f_note equal-tempered from C3.
    function automatic logic [15:0] note_inc(input logic [5:0] c);
        case (c)
            6'd0:  return 16'd167;   6'd1:  return 16'd177;   6'd2:  return 16'd188;
            6'd3:  return 16'd199;   6'd4:  return 16'd211;   6'd5:  return 16'd224;
            6'd6:  return 16'd237;   6'd7:  return 16'd251;   6'd8:  return 16'd266;
            6'd9:  return 16'd282;   6'd10: return 16'd298;   6'd11: return 16'd316;
            6'd12: return 16'd335;   6'd13: return 16'd355;   6'd14: return 16'd376;
            6'd15: return 16'd398;   6'd16: return 16'd422;   6'd17: return 16'd447;
            6'd18: return 16'd474;   6'd19: return 16'd502;   6'd20: return 16'd532;
            6'd21: return 16'd563;   6'd22: return 16'd597;   6'd23: return 16'd632;
            6'd24: return 16'd670;   6'd25: return 16'd710;   6'd26: return 16'd752;
            6'd27: return 16'd796;   6'd28: return 16'd844;   6'd29: return 16'd894;
            6'd30: return 16'd947;   6'd31: return 16'd1004;  6'd32: return 16'd1063;
            6'd33: return 16'd1126;  6'd34: return 16'd1193;  6'd35: return 16'd1264;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic illegal_code(input logic [5:0] c);
        return ({26'd0, c} >= 32'(NOTE_COUNT));
    endfunction

    // Parallel voice scan; descending loop leaves the lowest matching index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        for (int i = 3; i >= 0; i--) begin
            if (active_q[i] && held_q[i] == code_q) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
            if (!active_q[i]) begin
                free     = 1'b1;
                free_idx = 2'(i);
            end
            if (rank_q[i] == 2'd3) old_idx = 2'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        on_d     = on_q;
        key_d    = key_q;
        active_d = active_q;
        sound_d  = sound_q;
        held_d   = held_q;
        rank_d   = rank_q;
        target_d = target_q;
        gap_d    = gap_q;
        err_d    = 1'b0;
        if (iAll_off) begin
            key_d    = '0;
            sound_d  = '0;
            active_d = '0;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iNote_valid && ready_q) begin
                        code_d  = iNote_code;
                        on_d    = iNote_on;
                        err_d   = illegal_code(iNote_code);
                        state_d = MATCH;
                    end
                end
                MATCH: begin
                    state_d = IDLE;
                    if (!illegal_code(code_q)) begin
                        if (!on_q) begin
                            if (hit) begin
                                key_d[hit_idx]    = 1'b0;
                                active_d[hit_idx] = 1'b0;
                            end
                        end else if (!hit) begin
                            if (free) begin
                                target_d = free_idx;
                                state_d  = COMMIT;
                            end else begin
                                target_d = old_idx;
                                gap_d    = GAP_W'(STEAL_GAP - 1);
                                state_d  = GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // Key is forced low from the first GAP cycle so the silence spans the full count.
                    key_d[target_q] = 1'b0;
                    if (gap_q == '0) state_d = COMMIT;
                    else             gap_d   = gap_q - 1'b1;
                end
                COMMIT: begin
                    key_d[target_q]    = 1'b1;
                    sound_d[target_q]  = note_inc(code_q);
                    held_d[target_q]   = code_q;
                    active_d[target_q] = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (rank_q[i] < rank_q[target_q]) rank_d[i] = rank_q[i] + 2'd1;
                    end
                    rank_d[target_q] = 2'd0;
                    state_d          = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge iCLK_18_4 or posedge iRST) begin
        if (iRST) begin
            state_q  <= IDLE;
            code_q   <= '0;
            on_q     <= 1'b0;
            key_q    <= '0;
            active_q <= '0;
            sound_q  <= '0;
            held_q   <= '0;
            rank_q   <= {2'd3, 2'd2, 2'd1, 2'd0};
            target_q <= '0;
            gap_q    <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            on_q     <= on_d;
            key_q    <= key_d;
            active_q <= active_d;
            sound_q  <= sound_d;
            held_q   <= held_d;
            rank_q   <= rank_d;
            target_q <= target_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign oNote_ready = ready_q;
    assign oErr        = err_q;
    assign oKey1_on    = key_q[0];
    assign oKey2_on    = key_q[1];
    assign oKey3_on    = key_q[2];
    assign oKey4_on    = key_q[3];
    assign oSound1     = sound_q[0];
    assign oSound2     = sound_q[1];
    assign oSound3     = sound_q[2];
    assign oSound4     = sound_q[3];

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus randomized events against a
// transaction-level voice model (allocation-order queue, real-valued pitch formula).
module tb_voice_allocator;

    localparam int STEAL_GAP = 768;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid, on, all_off;
    logic [5:0]        code;
    logic              ready, err;
    logic [3:0]        key;
    logic [3:0][15:0]  snd;

    int errors = 0;
    int checks = 0;

    // Model: per-voice state plus allocation order, oldest first.
    bit  m_active [4];
    int  m_held   [4];
    bit  m_key    [4];
    int  m_sound  [4];
    int  m_order  [$];

    always #5 clk = ~clk;

    voice_allocator #(.NOTE_COUNT(36), .STEAL_GAP(STEAL_GAP)) dut (
        .iCLK_18_4 (clk),
        .iRST      (rst),
        .iNote_valid(valid),
        .iNote_code(code),
        .iNote_on  (on),
        .oNote_ready(ready),
        .iAll_off  (all_off),
        .oKey1_on  (key[0]),
        .oKey2_on  (key[1]),
        .oKey3_on  (key[2]),
        .oKey4_on  (key[3]),
        .oSound1   (snd[0]),
        .oSound2   (snd[1]),
        .oSound3   (snd[2]),
        .oSound4   (snd[3]),
        .oErr      (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_inc(input int c);
        real f;
        f = 440.0 * (2.0 ** ((c - 21) / 12.0));
        return $rtoi(f * 1.28 + 0.5);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_active[v] = 0; m_held[v] = 0; m_key[v] = 0; m_sound[v] = 0;
        end
        m_order = {3, 2, 1, 0};
    endtask

    task automatic model_all_off();
        for (int v = 0; v < 4; v++) begin
            m_active[v] = 0; m_key[v] = 0; m_sound[v] = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("%s_key%0d", tag, v + 1), int'(key[v]), int'(m_key[v]));
            chk($sformatf("%s_snd%0d", tag, v + 1), int'(snd[v]), m_sound[v]);
        end
        chk({tag, "_ready"}, int'(ready), 1);
    endtask

    // One event end to end; outputs are sampled on negedges.
    task automatic send_event(input int c, input bit press);
        int  kind, tgt, busy, low, errs, hit;
        bit  done;
        hit = -1; kind = 0; tgt = 0;
        for (int v = 0; v < 4; v++)
            if (m_active[v] && m_held[v] == c) hit = v;
        if (c < 36 && press && hit < 0) begin
            kind = 2;
            for (int v = 3; v >= 0; v--)
                if (!m_active[v]) begin kind = 1; tgt = v; end
            if (kind == 2) tgt = m_order[0];
        end
        @(negedge clk);
        valid = 1'b1; code = 6'(c); on = press;
        @(negedge clk);
        valid = 1'b0;
        chk("err_pulse", int'(err), (c >= 36) ? 1 : 0);
        busy = 0; low = 0; errs = 0; done = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (ready) done = 1;
            else begin
                busy++;
                errs += int'(err);
                if (kind == 2 && !key[tgt]) low++;
                @(negedge clk);
            end
        end
        chk("ready_timeout", int'(done), 1);
        chk("busy_cycles", busy, (kind == 1) ? 2 : (kind == 2) ? STEAL_GAP + 2 : 1);
        chk("err_count", errs, (c >= 36) ? 1 : 0);
        if (kind == 2) chk("gap_low", low, STEAL_GAP);
        if (c < 36 && !press && hit >= 0) begin
            m_key[hit] = 0; m_active[hit] = 0;
        end
        if (kind != 0) begin
            m_key[tgt] = 1; m_active[tgt] = 1; m_held[tgt] = c; m_sound[tgt] = exp_inc(c);
            for (int i = 0; i < m_order.size(); i++)
                if (m_order[i] == tgt) begin m_order.delete(i); break; end
            m_order.push_back(tgt);
        end
        check_outputs($sformatf("ev%0d_%0d", c, press));
    endtask

    task automatic do_all_off();
        @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        model_all_off();
        check_outputs("alloff");
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; on = 1'b0; all_off = 1'b0; code = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        chk("reset_err", int'(err), 0);
        rst = 1'b0;

        send_event(21, 1);
        chk("lut_a4", int'(snd[0]), 563);

        do_all_off();
        send_event(0, 1);
        send_event(12, 1);
        send_event(24, 1);
        send_event(35, 1);
        chk("lut_c3", int'(snd[0]), 167);
        chk("lut_b5", int'(snd[3]), 1264);
        send_event(12, 0);
        chk("release_key2", int'(key[1]), 0);

        do_all_off();
        send_event(0, 1);
        send_event(12, 1);
        send_event(24, 1);
        send_event(35, 1);
        send_event(21, 1);
        chk("steal_v1", int'(snd[0]), 563);
        send_event(5, 1);
        chk("steal_v2_key", int'(key[1]), 1);

        do_all_off();
        send_event(21, 1);
        send_event(21, 1);
        send_event(30, 0);
        send_event(40, 1);

        // Panic during a steal gap discards the pending allocation.
        send_event(3, 1);
        send_event(8, 1);
        send_event(13, 1);
        @(negedge clk);
        valid = 1'b1; code = 6'd17; on = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_gap_busy", int'(ready), 0);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        model_all_off();
        check_outputs("gap_alloff");
        repeat (STEAL_GAP + 10) @(negedge clk);
        check_outputs("gap_discard");

        // Event alongside panic is dropped.
        @(negedge clk);
        valid = 1'b1; code = 6'd50; on = 1'b1; all_off = 1'b1;
        @(negedge clk);
        valid = 1'b0; all_off = 1'b0;
        chk("alloff_noaccept_ready", int'(ready), 1);
        chk("alloff_noaccept_err", int'(err), 0);

        // Asynchronous reset while the allocator sits in COMMIT.
        send_event(2, 1);
        send_event(6, 1);
        @(negedge clk);
        valid = 1'b1; code = 6'd9; on = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        send_event(11, 1);
        chk("post_rst_voice1", int'(key[0]), 1);
        chk("post_rst_voice1_snd", int'(snd[0]), exp_inc(11));

        for (int e = 0; e < 80; e++) begin
            int c;
            if ($urandom_range(0, 15) == 0) do_all_off();
            if ($urandom_range(0, 9) == 0) c = $urandom_range(36, 63);
            else c = $urandom_range(0, 7) * 5;
            send_event(c, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
